test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameters: DATA_W, 32, width of compared words (multiple of 8, >=8).
REQ-002 SHALL have parameters: CNT_W, 32, cycle-counter width (multiple of 8, >=8).
REQ-003 SHALL have parameters: TIMEOUT_CYCLES, 100000, RUN cycles before timeout; 0 disables timeout.
REQ-004 SHALL have parameters: PASS_SIG, 'h600D; FAIL_SIG, 'hDEAD; TAG_SIG, 'hBEEF; all DATA_W wide.
REQ-005 SHALL have ports: clock, in, 1, sole clock, rising-edge.
REQ-006 SHALL have ports: reset, in, 1, asynchronous, active-low.
REQ-007 SHALL have ports: done_in, in, 1, DUT end-of-test flag (level).
REQ-008 SHALL have ports: sig_a_in and sig_b_in, in, DATA_W each, status and tag signature words.
REQ-009 SHALL have ports: expected_in and actual_in, in, DATA_W each, result words.
REQ-010 SHALL have ports: serial_ready_in, in, 1, sink ready; serial_out, out, 8, report byte; serial_wren_out, out, 1, byte valid.
REQ-011 SHALL have ports: cycle_count_out, out, CNT_W; result_valid_out, pass_out, fail_out, timeout_out, out, 1 each.

Function
REQ-012 FSM states SHALL be RUN, EVAL, REPORT, HALT; RUN is entered on reset.
REQ-013 In RUN, cycle_count_out SHALL increment by 1 each cycle, saturate at 2^CNT_W-1, and freeze on leaving RUN.
REQ-014 RUN->EVAL SHALL occur on the first rising edge with done_in=1; sig_a_in, sig_b_in, expected_in and actual_in are captured on that edge.
REQ-015 RUN->REPORT with status 'T' (0x54) SHALL occur when cycle_count_out reaches TIMEOUT_CYCLES and done_in=0; if done_in=1 in the same cycle, done wins.
REQ-016 EVAL SHALL last exactly one cycle and classify: sig_a==PASS_SIG && sig_b==TAG_SIG -> 'P' (0x50); sig_a==FAIL_SIG && sig_b==TAG_SIG -> 'F' (0x46); otherwise 'E' (0x45).
REQ-017 result_valid_out SHALL go high on the EVAL->REPORT or timeout edge and stay high until reset; pass_out, fail_out and timeout_out are set with it per status ('E' sets none).
REQ-018 REPORT SHALL emit, in order: status byte, cycle_count_out as CNT_W/8 bytes MSB-first, then 0x0A.
REQ-019 Each byte SHALL be transferred when serial_wren_out=1 and serial_ready_in=1 on a rising edge; serial_out and serial_wren_out stay stable while serial_ready_in=0.
REQ-020 The first byte SHALL appear (serial_wren_out=1) in the first REPORT cycle; the next byte follows in the cycle after acceptance, with no bubble when serial_ready_in stays 1.
REQ-021 After 0x0A is accepted, the FSM SHALL enter HALT with serial_wren_out=0; HALT is left only by reset.
REQ-022 Changes to done_in in EVAL, REPORT or HALT SHALL be ignored.

Reset
REQ-023 reset=0 SHALL force RUN immediately and zero every output, counter, captured word and byte index, including during REPORT (a partial report is abandoned).
REQ-024 Counting SHALL start on the first rising edge after reset deasserts.

Configuration
REQ-025 When TEST_MONITOR_DIFF_EN is defined, status 'F' SHALL append expected then actual captured words (DATA_W/8 bytes each, MSB-first) between the count bytes and 0x0A.
REQ-026 When TEST_MONITOR_DIFF_EN is undefined, every report SHALL be exactly CNT_W/8+2 bytes, and no difference logic SHALL be built.

Verification
REQ-027 Defaults, ready=1, done_in high after 50 RUN cycles, sig_a=0x600D, sig_b=0xBEEF -> bytes 50 00 00 00 32 0A on 6 consecutive cycles; pass_out=1.
REQ-028 Same stimulus with sig_a=0xDEAD, expected=55, actual=34, DIFF_EN defined -> 46 00 00 00 32 00 00 00 37 00 00 00 22 0A; fail_out=1.
REQ-029 sig_a=0x1234 -> status 0x45; result_valid_out=1; pass_out, fail_out and timeout_out all 0.
REQ-030 TIMEOUT_CYCLES=20, done_in never set -> 54 00 00 00 14 0A; timeout_out=1; done_in raised in HALT has no effect.
REQ-031 serial_ready_in toggling 0/1 every cycle during REPORT -> every byte held stable until accepted, none lost or duplicated.
REQ-032 reset asserted after the third report byte -> outputs zero at once; after release, counting restarts from 0 and a fresh full report follows.

Source files
------------

// File: rtl/test_monitor.sv
// -----------------------------------------------------------------------------
// test_monitor
//
// End-of-test monitor for a simulated or emulated DUT. It counts cycles while
// the DUT runs. When the DUT raises done_in, the monitor captures its
// signature words and classifies the result as pass, fail or error. If
// TIMEOUT_CYCLES elapse first, it reports a timeout instead. It then streams a
// short report over a byte-wide ready/valid serial port and halts until reset.
//
// Report format: status byte ('P', 'F', 'E' or 'T'), then the cycle count as
// CNT_W/8 bytes MSB-first, then 0x0A.
//
// Optional feature (macro TEST_MONITOR_DIFF_EN): a 'F' report also carries
// the captured expected and actual words, DATA_W/8 bytes each and MSB-first.
// These bytes sit between the count and the 0x0A terminator. With the macro
// undefined, the result words are not stored at all.
//
// Ports
//   clock             rising-edge clock
//   reset             asynchronous active-low reset
//   done_in           DUT end-of-test level
//   sig_a_in          status signature word (PASS_SIG / FAIL_SIG)
//   sig_b_in          tag signature word (must equal TAG_SIG)
//   expected_in       expected result word
//   actual_in         actual result word
//   serial_ready_in   report sink ready
//   serial_out        report byte
//   serial_wren_out   report byte valid
//   cycle_count_out   RUN cycle count (saturating, frozen after RUN)
//   result_valid_out  a result has been decided (sticky until reset)
//   pass_out          result was 'P'
//   fail_out          result was 'F'
//   timeout_out       result was 'T'
// -----------------------------------------------------------------------------
module test_monitor #(
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                TIMEOUT_CYCLES = 100000,
  parameter logic [DATA_W-1:0] PASS_SIG       = DATA_W'(16'h600D),
  parameter logic [DATA_W-1:0] FAIL_SIG       = DATA_W'(16'hDEAD),
  parameter logic [DATA_W-1:0] TAG_SIG        = DATA_W'(16'hBEEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              done_in,
  input  logic [DATA_W-1:0] sig_a_in,
  input  logic [DATA_W-1:0] sig_b_in,
  input  logic [DATA_W-1:0] expected_in,
  input  logic [DATA_W-1:0] actual_in,
  input  logic              serial_ready_in,
  output logic [7:0]        serial_out,
  output logic              serial_wren_out,
  output logic [CNT_W-1:0]  cycle_count_out,
  output logic              result_valid_out,
  output logic              pass_out,
  output logic              fail_out,
  output logic              timeout_out
);

  localparam int CNT_B     = CNT_W / 8;
  localparam int DATA_B    = DATA_W / 8;
  localparam int MAX_BYTES = CNT_B + 2 * DATA_B + 2;
  localparam int IDX_W     = $clog2(MAX_BYTES + 1);

  localparam logic [7:0] ST_P  = 8'h50;
  localparam logic [7:0] ST_F  = 8'h46;
  localparam logic [7:0] ST_E  = 8'h45;
  localparam logic [7:0] ST_T  = 8'h54;
  localparam logic [7:0] EOL   = 8'h0A;

  // A timeout value the counter can never represent is treated as disabled.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                         ($clog2(TIMEOUT_CYCLES + 1) <= CNT_W);

  typedef enum logic [1:0] {RUN, EVAL, REPORT, HALT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  sig_a_q, sig_b_q;
  logic [7:0]         status_q, eval_status;
  logic [IDX_W-1:0]   idx_q, nxt_idx, last_idx;
  logic [7:0]         nxt_byte;
  logic [7:0]         serial_q;
  logic               wren_q;
  logic               valid_q, pass_q, fail_q, to_q;
  logic               timeout_hit;

`ifdef TEST_MONITOR_DIFF_EN
  logic [DATA_W-1:0]  exp_q, act_q;
`else
  logic               unused_diff;
  assign unused_diff = ^{expected_in, actual_in};
`endif

  // Saturating increment; the FSM only applies it while staying in RUN.
  assign count_d     = (&count_q) ? count_q : count_q + 1'b1;
  assign timeout_hit = TO_EN && (count_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    eval_status = ST_E;
    if (sig_b_q == TAG_SIG) begin
      if (sig_a_q == PASS_SIG)      eval_status = ST_P;
      else if (sig_a_q == FAIL_SIG) eval_status = ST_F;
    end
  end

  // Index of the terminator byte for the current report.
  always_comb begin
    last_idx = IDX_W'(CNT_B + 1);
`ifdef TEST_MONITOR_DIFF_EN
    if (status_q == ST_F) last_idx = IDX_W'(CNT_B + 2 * DATA_B + 1);
`endif
  end

  // Byte to present after the current one is accepted. Index 0 (status) is
  // loaded when REPORT is entered, so only indices >= 1 are decoded here;
  // anything not matched is the terminator.
  always_comb begin
    nxt_idx  = idx_q + 1'b1;
    nxt_byte = EOL;
    for (int i = 0; i < CNT_B; i++) begin
      if (nxt_idx == IDX_W'(i + 1)) nxt_byte = count_q[8*(CNT_B-1-i) +: 8];
    end
`ifdef TEST_MONITOR_DIFF_EN
    if (status_q == ST_F) begin
      for (int i = 0; i < DATA_B; i++) begin
        if (nxt_idx == IDX_W'(CNT_B + 1 + i))
          nxt_byte = exp_q[8*(DATA_B-1-i) +: 8];
        if (nxt_idx == IDX_W'(CNT_B + 1 + DATA_B + i))
          nxt_byte = act_q[8*(DATA_B-1-i) +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      count_q  <= '0;
      sig_a_q  <= '0;
      sig_b_q  <= '0;
`ifdef TEST_MONITOR_DIFF_EN
      exp_q    <= '0;
      act_q    <= '0;
`endif
      status_q <= '0;
      idx_q    <= '0;
      serial_q <= '0;
      wren_q   <= 1'b0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // done_in takes priority over a timeout on the same edge; the count
          // is not advanced on the edge that leaves RUN.
          if (done_in) begin
            state_q <= EVAL;
            sig_a_q <= sig_a_in;
            sig_b_q <= sig_b_in;
`ifdef TEST_MONITOR_DIFF_EN
            exp_q   <= expected_in;
            act_q   <= actual_in;
`endif
          end else if (timeout_hit) begin
            state_q  <= REPORT;
            status_q <= ST_T;
            serial_q <= ST_T;
            wren_q   <= 1'b1;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            to_q     <= 1'b1;
          end else begin
            count_q <= count_d;
          end
        end
        EVAL: begin
          state_q  <= REPORT;
          status_q <= eval_status;
          serial_q <= eval_status;
          wren_q   <= 1'b1;
          idx_q    <= '0;
          valid_q  <= 1'b1;
          pass_q   <= (eval_status == ST_P);
          fail_q   <= (eval_status == ST_F);
        end
        REPORT: begin
          if (wren_q && serial_ready_in) begin
            if (idx_q == last_idx) begin
              state_q  <= HALT;
              wren_q   <= 1'b0;
              serial_q <= '0;
            end else begin
              idx_q    <= nxt_idx;
              serial_q <= nxt_byte;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign serial_out       = serial_q;
  assign serial_wren_out  = wren_q;
  assign cycle_count_out  = count_q;
  assign result_valid_out = valid_q;
  assign pass_out         = pass_q;
  assign fail_out         = fail_q;
  assign timeout_out      = to_q;

endmodule

// File: tb/tb_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_monitor
//
// Bench for test_monitor. Main instance uses default parameters; a second
// instance uses TIMEOUT_CYCLES=20 and a third uses CNT_W=8 with no timeout to
// reach counter saturation. Expected report bytes are pushed to a queue when
// the stimulus is applied and compared against bytes accepted by the sink.
// -----------------------------------------------------------------------------
module tb_test_monitor;

  logic        clock = 1'b0;
  logic        rst_n, rst_to_n, rst_sat_n;
  logic        done, done_to;
  logic [31:0] sig_a, sig_b, exp_w, act_w;
  logic        ready;

  logic [7:0]  ser, ser_to, ser_sat;
  logic        wren, wren_to, wren_sat;
  logic [31:0] cnt, cnt_to;
  logic [7:0]  cnt_sat;
  logic        vld, pass, fail, tmo;
  logic        vld_to, pass_to, fail_to, tmo_to;
  logic        vld_sat, pass_sat, fail_sat, tmo_sat;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [7:0]  rx2_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  test_monitor u_dut (
    .clock(clock), .reset(rst_n), .done_in(done),
    .sig_a_in(sig_a), .sig_b_in(sig_b), .expected_in(exp_w), .actual_in(act_w),
    .serial_ready_in(ready), .serial_out(ser), .serial_wren_out(wren),
    .cycle_count_out(cnt), .result_valid_out(vld), .pass_out(pass),
    .fail_out(fail), .timeout_out(tmo)
  );

  test_monitor #(.TIMEOUT_CYCLES(20)) u_dut_to (
    .clock(clock), .reset(rst_to_n), .done_in(done_to),
    .sig_a_in(sig_a), .sig_b_in(sig_b), .expected_in(exp_w), .actual_in(act_w),
    .serial_ready_in(ready), .serial_out(ser_to), .serial_wren_out(wren_to),
    .cycle_count_out(cnt_to), .result_valid_out(vld_to), .pass_out(pass_to),
    .fail_out(fail_to), .timeout_out(tmo_to)
  );

  test_monitor #(.CNT_W(8), .TIMEOUT_CYCLES(0)) u_dut_sat (
    .clock(clock), .reset(rst_sat_n), .done_in(1'b0),
    .sig_a_in(sig_a), .sig_b_in(sig_b), .expected_in(exp_w), .actual_in(act_w),
    .serial_ready_in(ready), .serial_out(ser_sat), .serial_wren_out(wren_sat),
    .cycle_count_out(cnt_sat), .result_valid_out(vld_sat), .pass_out(pass_sat),
    .fail_out(fail_sat), .timeout_out(tmo_sat)
  );

  // Sink: a byte shown with wren=1 and ready=1 at the falling edge is
  // transferred on the next rising edge (inputs only change just after rising).
  always @(negedge clock) begin
    if (wren && ready) begin
      rx_q.push_back(ser);
      rx_t.push_back(cyc);
    end
    if (wren_to && ready) rx2_q.push_back(ser_to);
  end

  // Reference model of one report.
  task automatic push_report(input logic [7:0] st, input logic [31:0] count,
                             input logic [31:0] e, input logic [31:0] a);
    logic [31:0] c, ev, av;
    c = count; ev = e; av = a;
    exp_q.push_back(st);
    for (int i = 3; i >= 0; i--) exp_q.push_back(c[8*i +: 8]);
`ifdef TEST_MONITOR_DIFF_EN
    if (st == 8'h46) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(ev[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(av[8*i +: 8]);
    end
`endif
    exp_q.push_back(8'h0A);
  endtask

  // Reset main instance, run 50 counted cycles, then raise done.
  task automatic start_run(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input logic [31:0] ac);
    rst_n = 1'b0; done = 1'b0;
    sig_a = a; sig_b = b; exp_w = e; act_w = ac;
    @(posedge clock); #1;
    exp_q.delete(); rx_q.delete(); rx_t.delete();
    rst_n = 1'b1;
    repeat (50) @(posedge clock);
    #1 done = 1'b1;
  endtask

  task automatic wait_rx(input int n, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      if (rx_q.size() >= n) begin expired = 1'b0; break; end
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst_to_n = 1'b0; rst_sat_n = 1'b0;
    done = 1'b0; done_to = 1'b0; ready = 1'b1;
    sig_a = '0; sig_b = '0; exp_w = '0; act_w = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({ser, wren, cnt, vld, pass, fail, tmo} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ser=%h wren=%b cnt=%0d vld=%b p=%b f=%b t=%b required all zero",
               ser, wren, cnt, vld, pass, fail, tmo);
    end
    n_cmp++;
    if ({ser_to, wren_to, cnt_to, vld_to, tmo_to} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_to: got ser=%h wren=%b cnt=%0d vld=%b t=%b required all zero",
               ser_to, wren_to, cnt_to, vld_to, tmo_to);
    end
  endtask

  task automatic test_pass;
    bit   expired;
    int   t0;
    logic [7:0] e, r;
    start_run(32'h600D, 32'hBEEF, 32'd0, 32'd0);
    n_cmp++;
    if (cnt !== 32'd50) begin
      n_bad++; $display("FAIL pass_count_at_done: got %0d required 50", cnt);
    end
    push_report(8'h50, 32'd50, 32'd0, 32'd0);
    wait_rx(exp_q.size(), expired);
    n_cmp++;
    if (expired || rx_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL pass_byte_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    t0 = (rx_t.size() > 0) ? rx_t[0] : 0;
    for (int i = 0; i < rx_t.size(); i++) begin
      n_cmp++;
      if (rx_t[i] != t0 + i) begin
        n_bad++; $display("FAIL pass_consecutive[%0d]: got cycle %0d required %0d", i, rx_t[i], t0 + i);
      end
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL pass_byte: got %h required %h", r, e); end
    end
    n_cmp++;
    if ({vld, pass, fail, tmo, wren} !== 5'b11000) begin
      n_bad++; $display("FAIL pass_flags: got vld/p/f/t/wren=%b required 11000", {vld, pass, fail, tmo, wren});
    end
    // done_in activity after the report must be ignored.
    done = 1'b0; repeat (3) @(posedge clock); #1 done = 1'b1;
    repeat (5) @(posedge clock); #1;
    n_cmp++;
    if (rx_q.size() != 0 || cnt !== 32'd50 || wren !== 1'b0) begin
      n_bad++; $display("FAIL pass_halt_ignores_done: got bytes=%0d cnt=%0d wren=%b required 0/50/0",
                        rx_q.size(), cnt, wren);
    end
  endtask

  task automatic test_fail;
    bit   expired;
    logic [7:0] e, r;
    start_run(32'hDEAD, 32'hBEEF, 32'd55, 32'd34);
    push_report(8'h46, 32'd50, 32'd55, 32'd34);
    wait_rx(exp_q.size(), expired);
    n_cmp++;
    if (expired || rx_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL fail_byte_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL fail_byte: got %h required %h", r, e); end
    end
    n_cmp++;
    if ({vld, pass, fail, tmo} !== 4'b1010) begin
      n_bad++; $display("FAIL fail_flags: got vld/p/f/t=%b required 1010", {vld, pass, fail, tmo});
    end
  endtask

  task automatic test_error;
    bit   expired;
    logic [7:0] e, r;
    start_run(32'h1234, 32'hBEEF, 32'd7, 32'd9);
    push_report(8'h45, 32'd50, 32'd7, 32'd9);
    wait_rx(exp_q.size(), expired);
    n_cmp++;
    if (expired || rx_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL error_byte_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL error_byte: got %h required %h", r, e); end
    end
    n_cmp++;
    if ({vld, pass, fail, tmo} !== 4'b1000) begin
      n_bad++; $display("FAIL error_flags: got vld/p/f/t=%b required 1000", {vld, pass, fail, tmo});
    end
    // Right pass signature with a wrong tag is also an error.
    start_run(32'h600D, 32'h1111, 32'd0, 32'd0);
    push_report(8'h45, 32'd50, 32'd0, 32'd0);
    wait_rx(exp_q.size(), expired);
    n_cmp++;
    if (expired || rx_q.size() == 0 || rx_q[0] !== 8'h45 || pass !== 1'b0) begin
      n_bad++; $display("FAIL error_bad_tag: got status %h pass=%b required 45/0",
                        (rx_q.size() > 0) ? rx_q[0] : 8'hxx, pass);
    end
  endtask

  task automatic test_backpressure;
    bit   held;
    logic [7:0] held_b, e, r;
    start_run(32'h600D, 32'hBEEF, 32'd0, 32'd0);
    push_report(8'h50, 32'd50, 32'd0, 32'd0);
    held = 1'b0; held_b = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1 ready = ~ready;
      @(negedge clock);
      if (held) begin
        n_cmp++;
        if (wren !== 1'b1 || ser !== held_b) begin
          n_bad++; $display("FAIL bp_hold: got wren=%b byte=%h required 1/%h", wren, ser, held_b);
        end
      end
      held = wren && !ready;
      held_b = ser;
    end
    ready = 1'b1;
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL bp_byte_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL bp_byte: got %h required %h", r, e); end
    end
  endtask

  task automatic test_reset_mid_report;
    bit   expired;
    logic [7:0] e, r;
    start_run(32'h600D, 32'hBEEF, 32'd0, 32'd0);
    expired = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (rx_q.size() >= 3) begin expired = 1'b0; break; end
    end
    rst_n = 1'b0; done = 1'b0;
    #1;
    n_cmp++;
    if (expired || {ser, wren, cnt, vld, pass, fail, tmo} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: got ser=%h wren=%b cnt=%0d vld=%b p=%b required all zero",
                        ser, wren, cnt, vld, pass);
    end
    @(posedge clock); #1;
    rx_q.delete(); rx_t.delete(); exp_q.delete();
    rst_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if (cnt !== 32'd5) begin
      n_bad++; $display("FAIL midrst_restart_count: got %0d required 5", cnt);
    end
    repeat (45) @(posedge clock);
    #1 done = 1'b1;
    push_report(8'h50, 32'd50, 32'd0, 32'd0);
    wait_rx(exp_q.size(), expired);
    n_cmp++;
    if (expired || rx_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL midrst_byte_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL midrst_byte: got %h required %h", r, e); end
    end
  endtask

  task automatic test_timeout;
    bit   expired;
    logic [7:0] exp2_q[$];
    logic [7:0] e, r;
    rx2_q.delete();
    exp2_q = '{8'h54, 8'h00, 8'h00, 8'h00, 8'h14, 8'h0A};
    done_to = 1'b0;
    @(posedge clock); #1 rst_to_n = 1'b1;
    expired = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (rx2_q.size() >= 6) begin expired = 1'b0; break; end
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (expired || rx2_q.size() != 6) begin
      n_bad++; $display("FAIL timeout_byte_count: got %0d required 6", rx2_q.size());
    end
    while (exp2_q.size() > 0 && rx2_q.size() > 0) begin
      e = exp2_q.pop_front(); r = rx2_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL timeout_byte: got %h required %h", r, e); end
    end
    n_cmp++;
    if ({vld_to, pass_to, fail_to, tmo_to} !== 4'b1001 || cnt_to !== 32'd20) begin
      n_bad++; $display("FAIL timeout_flags: got vld/p/f/t=%b cnt=%0d required 1001/20",
                        {vld_to, pass_to, fail_to, tmo_to}, cnt_to);
    end
    done_to = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++;
    if (rx2_q.size() != 0 || wren_to !== 1'b0 || cnt_to !== 32'd20 || pass_to !== 1'b0) begin
      n_bad++; $display("FAIL timeout_halt_done: got bytes=%0d wren=%b cnt=%0d pass=%b required 0/0/20/0",
                        rx2_q.size(), wren_to, cnt_to, pass_to);
    end
  endtask

  task automatic test_saturate;
    @(posedge clock); #1 rst_sat_n = 1'b1;
    repeat (300) @(posedge clock);
    #1;
    n_cmp++;
    if (cnt_sat !== 8'hFF || vld_sat !== 1'b0 || wren_sat !== 1'b0) begin
      n_bad++; $display("FAIL saturate: got cnt=%h vld=%b wren=%b required ff/0/0", cnt_sat, vld_sat, wren_sat);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_error();
    test_backpressure();
    test_reset_mid_report();
    test_timeout();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
